custom_mult_seq: RTL

//  Parametrised multicycle shift-add multiplier behind the Nios II custom-instruction port.

---
 rtl/custom_mult_seq_if.sv | 23 ++
 rtl/custom_mult_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/custom_mult_seq_if.sv
// Custom-instruction port bundle for the sequential multiplier.
// The master drives the request and operands; the slave returns done and result.
interface custom_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             clk_en;
   logic             start;
   logic [WIDTH-1:0] dataa;
   logic [WIDTH-1:0] datab;
   logic [1:0]       n;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output clk_en, start, dataa, datab, n,
      input  done, result
   );

   modport slave (
      input  clk_en, start, dataa, datab, n,
      output done, result
   );
endinterface

// File: rtl/custom_mult_seq.sv
// Multicycle shift-add multiplier: signed/unsigned, low/high half, one multiplier bit per enabled cycle.
// Latency WIDTH+1 enabled edges, or fewer with EARLY_EXIT; clk_en low freezes every register.
module custom_mult_seq #(
   parameter int WIDTH      = 32,
   parameter int EARLY_EXIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   custom_mult_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               sgn_q, sgn_d;
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic [CW-1:0]      shamt;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH-1:0]   mplr_shift;

   always_comb begin
      state_d  = state_q;
      sgn_d    = sgn_q;
      hi_d     = hi_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      result_d = result_q;

      // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
      a_abs      = bus.dataa[WIDTH-1] ? ('0 - bus.dataa) : bus.dataa;
      b_abs      = bus.datab[WIDTH-1] ? ('0 - bus.datab) : bus.datab;
      shamt      = CW'(WIDTH) - cnt_q;
      addend     = {{WIDTH{1'b0}}, mcand_q} << shamt;
      prod       = sgn_q ? ('0 - acc_q) : acc_q;
      mplr_shift = mplr_q >> 1;

      if (bus.clk_en) begin
         case (state_q)
            IDLE: begin
               done_d = 1'b0;
               if (bus.start) begin
                  hi_d  = bus.n[0];
                  acc_d = '0;
                  cnt_d = CW'(WIDTH);
                  if (bus.n[1]) begin
                     sgn_d   = bus.dataa[WIDTH-1] ^ bus.datab[WIDTH-1];
                     mcand_d = a_abs;
                     mplr_d  = b_abs;
                  end else begin
                     sgn_d   = 1'b0;
                     mcand_d = bus.dataa;
                     mplr_d  = bus.datab;
                  end
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (mplr_q[0]) begin
                  acc_d = acc_q + addend;
               end
               mplr_d = mplr_shift;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == CW'(1) || (EARLY_EXIT != 0 && mplr_shift == '0)) begin
                  state_d = FIN;
               end
            end
            FIN: begin
               result_d = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
               done_d   = 1'b1;
               state_d  = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sgn_q    <= 1'b0;
         hi_q     <= 1'b0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sgn_q    <= sgn_d;
         hi_q     <= hi_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule
